// File: rtl/midi_tx_arbiter.sv
// midi_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ MIDI sources, one whole message per grant.
// Define MIDI_RUNNING_STATUS_EN to suppress repeated channel-status bytes (MIDI running status).
module midi_tx_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                   i_Clock,
  input  logic                   i_Rst_n,
  input  logic [NUM_REQ-1:0]     i_Req,
  input  logic [24*NUM_REQ-1:0]  i_Msg,
  input  logic [2*NUM_REQ-1:0]   i_Msg_Len,
  output logic [NUM_REQ-1:0]     o_Gnt,
  output logic                   o_Tx_DV,
  output logic [7:0]             o_Tx_Byte,
  input  logic                   i_Tx_Done,
  output logic                   o_Busy
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  state_t state;
  logic [PW-1:0] ptr, win, cand;
  logic [23:0] msg, w_msg;
  logic [1:0] len, idx, w_len;
  logic skip;
  int j;
  always_comb begin
    win = '0;
    cand = '0;
    j = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = PW'(j);
      if (i_Req[cand]) win = cand;
    end
  end
  assign w_msg = i_Msg[24*int'(win) +: 24];
  assign w_len = i_Msg_Len[2*int'(win) +: 2];
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status;
  // last_status only ever holds 0x00 or a channel status, so a nonzero match is a channel-status repeat
  assign skip = (w_msg[7:0] == last_status) && (last_status != 8'h00);
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) last_status <= 8'h00;
    else if (state == SEND && idx == 2'd0)
      last_status <= (msg[7:4] == 4'hF) ? (msg[3] ? last_status : 8'h00) : (msg[7] ? msg[7:0] : last_status);
`else
  assign skip = 1'b0;
`endif
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) begin
      state <= IDLE;
      ptr <= '0;
      msg <= '0;
      len <= '0;
      idx <= '0;
      o_Gnt <= '0;
      o_Tx_DV <= 1'b0;
      o_Tx_Byte <= '0;
      o_Busy <= 1'b0;
    end else begin
      o_Gnt <= '0;
      o_Tx_DV <= 1'b0;
      case (state)
        IDLE: if (|i_Req) begin
          o_Gnt <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
          ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
          msg <= w_msg;
          len <= w_len;
          idx <= {1'b0, skip};
          o_Busy <= w_len > {1'b0, skip};
          state <= (w_len > {1'b0, skip}) ? SEND : IDLE;
        end
        SEND: begin
          o_Tx_DV <= 1'b1;
          o_Tx_Byte <= msg[{idx, 3'b000} +: 8];
          state <= WAIT;
        end
        WAIT: if (i_Tx_Done) begin
          if ({1'b0, idx} + 3'd1 < {1'b0, len}) begin
            idx <= idx + 2'd1;
            state <= SEND;
          end else begin
            o_Busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_midi_tx_arbiter.sv
// tb_midi_tx_arbiter: random requests against a message-level arbitration/running-status model.
module tb_midi_tx_arbiter;
  localparam int N = 4;
  logic i_Clock = 1'b0;
  logic i_Rst_n;
  logic [N-1:0] i_Req;
  logic [24*N-1:0] i_Msg;
  logic [2*N-1:0] i_Msg_Len;
  logic i_Tx_Done;
  logic [N-1:0] o_Gnt;
  logic o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic o_Busy;
  int checks = 0;
  int failures = 0;
  int ptr_m = 0;
  logic [7:0] last_m = 8'h00;
  logic [7:0] hint_m = 8'h90;
  always #5 i_Clock = ~i_Clock;
  midi_tx_arbiter #(.NUM_REQ(N)) dut (
    .i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .i_Req(i_Req), .i_Msg(i_Msg),
    .i_Msg_Len(i_Msg_Len), .o_Gnt(o_Gnt), .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte),
    .i_Tx_Done(i_Tx_Done), .o_Busy(o_Busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] pick_status();
    logic [7:0] s;
    case ($urandom_range(0, 5))
      0, 1: s = hint_m;
      2: s = 8'($urandom_range(128, 239));
      3: s = 8'($urandom_range(240, 247));
      4: s = 8'($urandom_range(248, 255));
      default: s = 8'($urandom_range(0, 127));
    endcase
    if (s >= 8'h80 && s <= 8'hEF) hint_m = s;
    return s;
  endfunction
  task automatic fresh();
    int x;
    i_Req = ($urandom_range(0, 3) == 0) ? '0 : 4'($urandom_range(1, 15));
    for (int k = 0; k < N; k++) begin
      i_Msg[24*k +: 24] = {8'($urandom_range(0, 127)), 8'($urandom_range(0, 127)), pick_status()};
      x = $urandom_range(0, 6);
      i_Msg_Len[2*k +: 2] = (x == 0) ? 2'd0 : 2'(1 + x % 3);
    end
  endtask
  task automatic scramble();
    i_Req = 4'($urandom());
    i_Msg = {$urandom(), $urandom(), $urandom()};
    i_Msg_Len = 8'($urandom());
  endtask
  initial begin
    int k, jj, len, start;
    logic [23:0] m;
    logic [7:0] b0;
    logic [7:0] exp_q[$];
    bit rst_done;
    rst_done = 0;
    i_Rst_n = 1'b0;
    i_Req = '0;
    i_Msg = '0;
    i_Msg_Len = '0;
    i_Tx_Done = 1'b0;
    repeat (2) @(negedge i_Clock);
    check("rst_gnt", 32'(o_Gnt), 0);
    check("rst_dv", 32'(o_Tx_DV), 0);
    check("rst_byte", 32'(o_Tx_Byte), 0);
    check("rst_busy", 32'(o_Busy), 0);
    i_Rst_n = 1'b1;
    for (int it = 0; it < 400; it++) begin
      fresh();
      if (i_Req == '0) begin
        i_Tx_Done = 1'($urandom_range(0, 1));
        @(posedge i_Clock); @(negedge i_Clock);
        i_Tx_Done = 1'b0;
        check("idle_gnt", 32'(o_Gnt), 0);
        check("idle_dv", 32'(o_Tx_DV), 0);
        check("idle_busy", 32'(o_Busy), 0);
        continue;
      end
      k = -1;
      for (int i = 0; i < N; i++) begin
        jj = (ptr_m + i) % N;
        if (k < 0 && i_Req[jj]) k = jj;
      end
      ptr_m = (k + 1) % N;
      m = i_Msg[24*k +: 24];
      len = int'(i_Msg_Len[2*k +: 2]);
      b0 = m[7:0];
      start = 0;
`ifdef MIDI_RUNNING_STATUS_EN
      if (len > 0 && b0 >= 8'h80 && b0 <= 8'hEF && b0 == last_m) start = 1;
      if (len > 0 && start == 0) begin
        if (b0 >= 8'h80 && b0 <= 8'hEF) last_m = b0;
        else if (b0 >= 8'hF0 && b0 <= 8'hF7) last_m = 8'h00;
      end
`endif
      exp_q.delete();
      for (int i = start; i < len; i++) exp_q.push_back(m[8*i +: 8]);
      @(posedge i_Clock); @(negedge i_Clock);
      check("gnt", 32'(o_Gnt), 32'(1 << k));
      check("gnt_dv", 32'(o_Tx_DV), 0);
      if (exp_q.size() == 0) continue;
      check("gnt_busy", 32'(o_Busy), 1);
      scramble();
      i_Tx_Done = 1'($urandom_range(0, 1));
      for (int b = 0; b < exp_q.size(); b++) begin
        @(posedge i_Clock); @(negedge i_Clock);
        i_Tx_Done = 1'b0;
        check("dv", 32'(o_Tx_DV), 1);
        check("byte", 32'(o_Tx_Byte), 32'(exp_q[b]));
        check("busy_tx", 32'(o_Busy), 1);
        if (!rst_done && it >= 200 && b == 0 && exp_q.size() > 1) begin
          rst_done = 1;
          i_Rst_n = 1'b0;
          #1;
          check("arst_gnt", 32'(o_Gnt), 0);
          check("arst_dv", 32'(o_Tx_DV), 0);
          check("arst_byte", 32'(o_Tx_Byte), 0);
          check("arst_busy", 32'(o_Busy), 0);
          @(negedge i_Clock);
          i_Rst_n = 1'b1;
          ptr_m = 0;
          last_m = 8'h00;
          break;
        end
        repeat ($urandom_range(1, 4)) begin
          @(posedge i_Clock); @(negedge i_Clock);
          check("gap_dv", 32'(o_Tx_DV), 0);
          check("gap_busy", 32'(o_Busy), 1);
          if ($urandom_range(0, 1) == 1) scramble();
        end
        i_Tx_Done = 1'b1;
        @(posedge i_Clock); @(negedge i_Clock);
        i_Tx_Done = 1'b0;
        check("done_dv", 32'(o_Tx_DV), 0);
        check("done_busy", 32'(o_Busy), 32'(b + 1 < exp_q.size()));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/midi_tx_arbiter.md
# midi_tx_arbiter

Shares one `uart_tx` serial transmitter among `NUM_REQ` MIDI message sources in the router. It picks requesters round-robin and sends each granted MIDI message (1–3 bytes) atomically, so bytes from different messages never interleave on the output port. It drives the transmitter's `i_Tx_DV`/`i_Tx_Byte` and paces itself on the transmitter's `o_Tx_Done` pulse.

## Interface
- `NUM_REQ`, default 4: number of requesters, valid range 2–8.
- `i_Clock` in 1: system clock.
- `i_Rst_n` in 1: reset, asynchronous, active-low.
- `i_Req` in NUM_REQ: per-requester message-pending level. Held until the matching grant.
- `i_Msg` in 24*NUM_REQ: message bytes per requester. Slice k is `[24k+23:24k]`; byte0 (status) is `[24k+7:24k]`, byte1 is next, byte2 is highest.
- `i_Msg_Len` in 2*NUM_REQ: byte count per requester, slice k is `[2k+1:2k]`. Values 1–3; 0 means no bytes.
- `o_Gnt` out NUM_REQ: one-cycle one-hot pulse; the message has been captured.
- `o_Tx_DV` out 1: one-cycle byte strobe to the transmitter.
- `o_Tx_Byte` out 8: byte to the transmitter, valid while `o_Tx_DV`=1.
- `i_Tx_Done` in 1: transmitter end-of-stop-bit pulse.
- `o_Busy` out 1: high from capture until the last byte's `i_Tx_Done`.

## Operation
- Reset values: all outputs 0; FSM = IDLE; round-robin pointer = 0; last-status register = 0x00.
- **IDLE**
  - If `i_Req`≠0, grant the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Capture `i_Msg`/`i_Msg_Len` of the winner and pulse `o_Gnt[k]`.
  - Set pointer to (k+1) mod NUM_REQ and byte index to 0.
  - Go to SEND, or back to IDLE if no bytes remain (len 0, or all bytes suppressed).
- **SEND**: assert `o_Tx_DV` for one cycle with the captured byte at the current index, then go to WAIT.
- **WAIT**: hold until `i_Tx_Done`=1.
  - If bytes remain: increment index and go to SEND.
  - Otherwise: go to IDLE and clear `o_Busy`.
- The captured message is immune to changes on `i_Req`/`i_Msg` after the grant.
- A request dropped before its grant is simply not served; this is not an error.
- `i_Tx_Done` seen in IDLE or SEND is ignored.
- Asynchronous reset mid-message abandons the remaining bytes. The transmitter finishes its current byte on its own.

## Timing
- Request sampled high at edge t (FSM in IDLE): `o_Gnt` and `o_Busy` are high in cycle t+1.
- First `o_Tx_DV` is high in cycle t+2.
- `i_Tx_Done` high in cycle d with bytes remaining: next `o_Tx_DV` is high in cycle d+2.
- `i_Tx_Done` high in cycle d on the last byte: `o_Busy` is low in cycle d+1, and the next arbitration is sampled at edge d+1.
- Only one `o_Tx_DV` is outstanding at a time; the block never strobes while a byte is in flight.
- A single requester with back-to-back messages gets a gap of 3 cycles plus transmitter time per message; it is never starved, and with several requesters waiting it waits at most NUM_REQ−1 messages.

## Configuration
- **`MIDI_RUNNING_STATUS_EN` defined**: the block tracks the last transmitted status byte.
  - A message whose byte0 is a channel status (0x80–0xEF) equal to that last status is sent without byte0, and the index starts at 1.
  - Any transmitted channel status updates the register.
  - A system-common or SysEx status (0xF0–0xF7) clears it to 0x00.
  - Real-time bytes (0xF8–0xFF) leave it unchanged.
  - Data-only messages (byte0 < 0x80) are sent verbatim and do not affect the register.
- **Undefined**: every byte is sent verbatim and the last-status register is not implemented.

## Test plan
- **Single request**: req0, msg {0x90,0x3C,0x64}, len 3 → `o_Gnt`=0001 at t+1; bytes 0x90, 0x3C, 0x64 each strobed 2 cycles after the previous `i_Tx_Done`; `o_Busy` falls 1 cycle after the third Done.
- **Round robin**: all four requesting continuously, len 1 each → grant order 0,1,2,3,0,1; no byte interleaving within any message.
- **Atomicity**: req1 rises mid-message of req0 → req1's grant only after req0's last Done; req1's bytes captured at that grant.
- **Len 0**: req2, len 0 → `o_Gnt`=0100, no `o_Tx_DV`, back to IDLE; pointer becomes 3.
- **Running status (macro defined)**: {0x90,0x3C,0x64} then {0x90,0x40,0x7F} → second message emits only 0x40, 0x7F. Then 0xF8 (len 1) followed by {0x90,0x41,0x10} → 0xF8 sent, 0x90 still suppressed. Without the macro, 0x90 is sent both times.
- **Reset mid-message**: assert `i_Rst_n`=0 after the first byte's DV → outputs 0 immediately; after release, the next request's first byte is sent in full, with status not suppressed.
